// File: rtl/rom_download_ctrl.sv
// ROM/expansion download sequencer: moves ioctl bytes into the SDRAM write port,
// one byte per refresh slot, optionally mirrored into both banks, and flags loaded pages.
module rom_download_ctrl #(
    parameter logic [8:0] DEFAULT_PAGE = 9'h1EE,
    parameter logic [8:0] MF2_PAGE     = 9'h1FF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic [15:0] ioctl_file_ext,
    output logic        ioctl_wait,
    output logic        mem_wr,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_dout,
    output logic        map_wr,
    output logic [7:0]  map_addr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SLOT_WAIT,
        WRITE,
        BANK2
    } state_t;

    localparam logic [15:0] EXT_ZZ = 16'h5A5A;
    localparam logic [15:0] EXT_Z0 = 16'h5A30;

    state_t      state_q,    state_d;
    logic        dl_q,       dl_d;
    logic [8:0]  page_q,     page_d;
    logic        combo_q,    combo_d;
    logic        wait_q,     wait_d;
    logic        busy_q,     busy_d;
    logic        mem_wr_q,   mem_wr_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_bank_q, mem_bank_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        map_wr_q,   map_wr_d;
    logic [7:0]  map_addr_q, map_addr_d;

    logic        dl_rise;
    logic [10:0] rom_blk;
    logic        dual_bank;
    logic        finish;

    function automatic logic is_hex_digit(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // 'A'..'F' have low nibble 1..6, so adding 9 lands on 10..15.
    function automatic logic [3:0] hex_value(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    // Returns {combo, page} chosen by the extension of an expansion file.
    function automatic logic [9:0] ext_decode(input logic [15:0] ext);
        logic [8:0] pg;
        logic       cmb;
        pg  = DEFAULT_PAGE;
        cmb = 1'b0;
        if (is_hex_digit(ext[15:8])) pg[7:4] = hex_value(ext[15:8]);
        if (is_hex_digit(ext[7:0]))  pg[3:0] = hex_value(ext[7:0]);
        if (ext == EXT_ZZ) begin
            pg = 9'h000;
        end else if (ext == EXT_Z0) begin
            pg  = 9'h000;
            cmb = 1'b1;
        end
        return {cmb, pg};
    endfunction

    // Base ROM set: the four 16 KB images of each bank land in fixed pages.
    function automatic logic [8:0] base_page(input logic [1:0] blk);
        case (blk)
            2'd0:    return 9'h000;
            2'd1:    return 9'h100;
            2'd2:    return 9'h107;
            default: return 9'h1FF;
        endcase
    endfunction

    assign dl_d      = ioctl_download;
    assign dl_rise   = ioctl_download && !dl_q;
    assign rom_blk   = ioctl_addr[24:14];
    assign dual_bank = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);

    // NOTE: every signal gets its default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        combo_d    = combo_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_bank_d = mem_bank_q;
        mem_dout_d = mem_dout_q;
        map_wr_d   = 1'b0;
        map_addr_d = map_addr_q;
        finish     = 1'b0;

        case (state_q)
            IDLE: begin
                // wait_q still set in IDLE means the last byte fell outside the base ROM set.
                if (wait_q) begin
                    wait_d = 1'b0;
                end else if (ioctl_wr) begin
                    wait_d = 1'b1;
                    if (ioctl_index == 8'd0) begin
                        if (rom_blk <= 11'd7) begin
                            mem_dout_d = ioctl_dout;
                            mem_addr_d = {base_page(rom_blk[1:0]), ioctl_addr[13:0]};
                            mem_bank_d = {1'b0, rom_blk[2]};
                            state_d    = SLOT_WAIT;
                        end
                    end else begin
                        mem_dout_d = ioctl_dout;
                        mem_addr_d = {page_q[8], page_q[7:0] + ioctl_addr[21:14], ioctl_addr[13:0]};
                        mem_bank_d = {1'b0, &ioctl_index[7:6]};
                        state_d    = SLOT_WAIT;
                    end
                end
            end

            SLOT_WAIT, BANK2: begin
                if (ce_ref) begin
                    mem_wr_d = 1'b1;
                    state_d  = WRITE;
                end
            end

            WRITE: begin
                if (ce_ref) begin
                    mem_wr_d = 1'b0;
                    if (dual_bank && (mem_bank_q == 2'd0)) begin
                        mem_bank_d = 2'd1;
                        state_d    = BANK2;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (finish) begin
            wait_d  = 1'b0;
            state_d = IDLE;
            if (mem_addr_q[22]) begin
                map_wr_d   = 1'b1;
                map_addr_d = mem_addr_q[21:14];
            end
            // A "Z0" combo file continues into the MF2 page once its first 16 KB is in.
            if (combo_q && (mem_addr_q[13:0] == 14'h3FFF)) begin
                combo_d = 1'b0;
                page_d  = MF2_PAGE;
            end
        end

        if (dl_rise) begin
            page_d  = DEFAULT_PAGE;
            combo_d = 1'b0;
            if (ioctl_index != 8'd0) {combo_d, page_d} = ext_decode(ioctl_file_ext);
        end

        if (dl_rise) begin
            busy_d = 1'b1;
        end else if (!ioctl_download && (state_d == IDLE) && !wait_d) begin
            busy_d = 1'b0;
        end
    end

    // NOTE: reset is synchronous, so it is just the highest-priority branch under the clock edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            page_q     <= DEFAULT_PAGE;
            combo_q    <= 1'b0;
            wait_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_bank_q <= '0;
            mem_dout_q <= '0;
            map_wr_q   <= 1'b0;
            map_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= dl_d;
            page_q     <= page_d;
            combo_q    <= combo_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_bank_q <= mem_bank_d;
            mem_dout_q <= mem_dout_d;
            map_wr_q   <= map_wr_d;
            map_addr_q <= map_addr_d;
        end
    end

    // The write strobe is gated by reset so an aborted write stops in the same cycle.
    assign mem_wr     = mem_wr_q && !reset;
    assign ioctl_wait = wait_q;
    assign mem_addr   = mem_addr_q;
    assign mem_bank   = mem_bank_q;
    assign mem_dout   = mem_dout_q;
    assign map_wr     = map_wr_q;
    assign map_addr   = map_addr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Scoreboard bench for rom_download_ctrl: a page-level reference model predicts SDRAM
// writes and ROM-map updates; a monitor compares them as the DUT produces them.
module tb_rom_download_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_ref;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [15:0] ioctl_file_ext;
    logic        ioctl_wait;
    logic        mem_wr;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_dout;
    logic        map_wr;
    logic [7:0]  map_addr;
    logic        busy;

    rom_download_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_ref         (ce_ref),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_file_ext (ioctl_file_ext),
        .ioctl_wait     (ioctl_wait),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_bank       (mem_bank),
        .mem_dout       (mem_dout),
        .map_wr         (map_wr),
        .map_addr       (map_addr),
        .busy           (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  bank;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_map[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    int m_page;
    bit m_combo;
    int base_tbl[4] = '{'h000, 'h100, 'h107, 'h1FF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Refresh slot strobe: one clock out of every sixteen.
    initial begin : ce_gen
        int cnt;
        cnt = 0;
        ce_ref = 1'b0;
        forever begin
            @(negedge clk_sys);
            cnt = (cnt + 1) % 16;
            ce_ref = (cnt == 0);
        end
    end

    function automatic bit hex_ok(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        return (c <= "9") ? int'(c) - 48 : int'(c) - 55;
    endfunction

    task automatic model_start(input logic [7:0] idx, input logic [15:0] ext);
        m_page  = 'h1EE;
        m_combo = 1'b0;
        if (idx != 0) begin
            if (hex_ok(ext[15:8])) m_page = (m_page & 'h10F) | (hex_val(ext[15:8]) * 16);
            if (hex_ok(ext[7:0]))  m_page = (m_page & 'h1F0) | hex_val(ext[7:0]);
            if (ext == "ZZ") m_page = 0;
            if (ext == "Z0") begin
                m_page  = 0;
                m_combo = 1'b1;
            end
        end
    endtask

    task automatic push_wr(input int a, input int bank, input logic [7:0] data);
        wr_t w;
        w.addr = a[22:0];
        w.bank = bank[1:0];
        w.data = data;
        exp_wr.push_back(w);
    endtask

    // Predicts the SDRAM writes and map update for one byte; skip = byte is dropped.
    task automatic model_byte(input logic [7:0] idx, input int addr, input logic [7:0] data,
                              output bit skip);
        int blk, off, pg, bank0, a, pg_lo;
        blk  = addr / 16384;
        off  = addr % 16384;
        skip = 1'b0;
        if (idx == 0) begin
            if (blk > 7) begin
                skip = 1'b1;
            end else begin
                pg = base_tbl[blk % 4];
                push_wr(pg * 16384 + off, blk / 4, data);
                if (pg >= 256) exp_map.push_back(8'(pg % 256));
            end
        end else begin
            pg_lo = ((m_page % 256) + (blk % 256)) % 256;
            a     = (m_page / 256) * (1 << 22) + pg_lo * 16384 + off;
            bank0 = (idx >= 8'hC0) ? 1 : 0;
            push_wr(a, bank0, data);
            if (bank0 == 0 && ((idx / 64) == 1 || (idx % 64) != 0)) push_wr(a, 1, data);
            if (m_page >= 256) exp_map.push_back(8'(pg_lo));
            if (m_combo && off == 16383) begin
                m_combo = 1'b0;
                m_page  = 'h1FF;
            end
        end
    endtask

    // Monitor: pops expectations whenever a write or map update appears.
    initial begin : monitor
        bit  prev_wr, prev_map, aborted;
        int  len;
        wr_t w;
        prev_wr = 1'b0; prev_map = 1'b0; aborted = 1'b0; len = 0;
        forever begin
            @(negedge clk_sys);
            if (reset) aborted = 1'b1;
            if (mem_wr && !prev_wr) begin
                len = 0;
                aborted = 1'b0;
                check("mem_wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("mem_addr", mem_addr, w.addr);
                    check("mem_bank", mem_bank, w.bank);
                    check("mem_dout", mem_dout, w.data);
                end
            end
            if (mem_wr) len++;
            if (!mem_wr && prev_wr && !aborted) check("mem_wr_len", len, 16);
            if (map_wr) begin
                check("map_wr_expected", exp_map.size() > 0, 1);
                if (exp_map.size() > 0) check("map_addr", map_addr, exp_map.pop_front());
                check("map_wr_single", prev_map, 0);
            end
            prev_wr  = mem_wr;
            prev_map = map_wr;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] cur_index;

    task automatic begin_download(input logic [7:0] idx, input logic [15:0] ext);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_file_ext = ext;
        ioctl_download = 1'b1;
        cur_index      = idx;
        model_start(idx, ext);
        repeat (2) @(negedge clk_sys);
        check("busy_during", busy, 1);
    endtask

    task automatic end_download();
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("busy_after", busy, 0);
    endtask

    task automatic send_byte(input int addr, input logic [7:0] data);
        bit skip;
        int t;
        model_byte(cur_index, addr, data, skip);
        repeat ($urandom_range(0, 6)) @(negedge clk_sys);
        ioctl_addr = addr[24:0];
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        check("wait_on_latch", ioctl_wait, 1);
        if ($urandom_range(0, 3) == 0) begin
            // A stray strobe while stalled must be ignored.
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'($urandom);
            ioctl_dout = 8'($urandom);
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            if (skip) check("wait_skip_release", ioctl_wait, 0);
        end else if (skip) begin
            @(negedge clk_sys);
            check("wait_skip_release", ioctl_wait, 0);
        end
        t = 0;
        while (ioctl_wait && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        check("wait_release", ioctl_wait, 0);
    endtask

    logic [7:0]  idx_tbl[8] = '{8'h00, 8'h01, 8'h41, 8'h81, 8'hC0, 8'hC1, 8'h02, 8'h7F};
    logic [15:0] ext_tbl[8] = '{"07", "1F", "ZZ", "Z0", "Q!", "a3", "F0", "9Z"};

    initial begin : stimulus
        int t;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        ioctl_file_ext = '0;
        cur_index      = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_busy", busy, 0);
        check("rst_map_wr", map_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_bank", mem_bank, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_map_addr", map_addr, 0);
        reset = 1'b0;

        // Base ROM set: page 0 bank 1, upper page 0x1FF, and an out-of-range block.
        begin_download(8'h00, "RO");
        send_byte('h10123, 8'hA5);
        send_byte('h0C001, 8'h3C);
        send_byte('h20000, 8'h77);
        end_download();

        // Dual-bank expansion, "07" -> page 0x107, offset block 1 -> 0x420002.
        begin_download(8'h41, "07");
        send_byte('h4002, 8'h5A);
        end_download();

        // Combo file rolls into the MF2 page after offset 0x3FFF.
        begin_download(8'h01, "Z0");
        send_byte('h3FFF, 8'h11);
        send_byte('h4000, 8'h22);
        end_download();

        begin_download(8'h01, "Q!");
        send_byte('h8123, 8'h33);
        end_download();
        begin_download(8'h02, "1F");
        send_byte('h0456, 8'h44);
        end_download();

        // Reset while a write is in flight.
        begin_download(8'h00, "RO");
        void'(model_byte_drop('h10010, 8'h99));
        ioctl_addr = 25'h10010;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        t = 0;
        while (!mem_wr && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        check("reset_test_write_started", mem_wr, 1);
        repeat (4) @(negedge clk_sys);
        #2 reset = 1'b1;
        #1 check("reset_mem_wr_immediate", mem_wr, 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("reset_mid_mem_wr", mem_wr, 0);
        check("reset_mid_wait", ioctl_wait, 0);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_mem_addr", mem_addr, 0);
        @(negedge clk_sys);
        #2 reset = 1'b0;

        begin_download(8'hC1, "3A");
        send_byte('h1C2BCD, 8'h5E);
        end_download();

        // Randomised downloads drawn from representative indices and extensions.
        for (int d = 0; d < 20; d++) begin
            logic [7:0]  idx;
            logic [15:0] ext;
            int          nbytes, addr;
            idx = idx_tbl[$urandom_range(0, 7)];
            ext = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ext_tbl[$urandom_range(0, 7)];
            begin_download(idx, ext);
            nbytes = $urandom_range(3, 8);
            for (int b = 0; b < nbytes; b++) begin
                if (idx == 0)
                    addr = $urandom_range(0, 9) * 16384 + $urandom_range(0, 16383);
                else
                    addr = int'($urandom_range(0, 32'h1FF_FFFF));
                if ($urandom_range(0, 3) == 0) addr = (addr & ~'h3FFF) | 'h3FFF;
                send_byte(addr, 8'($urandom));
            end
            end_download();
        end

        repeat (40) @(negedge clk_sys);
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_map_drained", exp_map.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Queues the single-bank write of the aborted byte; it is popped when mem_wr rises.
    function automatic bit model_byte_drop(input int addr, input logic [7:0] data);
        wr_t w;
        w.addr = 23'((addr / 16384 % 4 == 0 ? 0 : 0) + addr % 16384);
        w.bank = 2'd1;
        w.data = data;
        exp_wr.push_back(w);
        return 1'b1;
    endfunction

endmodule
